// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_stall_controller_pkg;

    localparam int REG_AW   = 5;
    localparam int ZERO_REG = 0;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_load_use_detect.sv
// Load-use hazard compare between the load in EX and the source operands in ID.
module hazard_load_use_detect
    import hazard_stall_controller_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic          memread,
    input  logic [AW-1:0] ex_rt,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          uses_rt,
    output logic          hazard
);

    // Writes to the zero register are discarded, so they never create a dependency.
    assign hazard = memread && (ex_rt != AW'(ZERO_REG)) &&
                    ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing around load-use stalls, mul/div EX occupancy and branch flushes.
module hazard_stall_controller #(
    parameter int REG_AW     = hazard_stall_controller_pkg::REG_AW,
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] ID_rs,
    input  logic [REG_AW-1:0] ID_rt,
    input  logic              ID_uses_rt,
    input  logic              IE_memread,
    input  logic [REG_AW-1:0] IE_rt,
    input  logic              IE_md_start,
    input  logic              branch_taken,
    output logic              pc_write,
    output logic              IF_ID_write,
    output logic              ID_bubble,
    output logic              IF_ID_flush,
    output logic              ID_EX_flush,
    output logic              EX_hold,
    output logic              md_done,
    output logic [CNT_W-1:0]  stall_cnt
);

    import hazard_stall_controller_pkg::*;

    state_t     state, state_nxt;
    logic [3:0] md_cnt, md_cnt_nxt;
    logic       lu_hazard;

    hazard_load_use_detect #(.AW(REG_AW)) u_lu (
        .memread (IE_memread),
        .ex_rt   (IE_rt),
        .id_rs   (ID_rs),
        .id_rt   (ID_rt),
        .uses_rt (ID_uses_rt),
        .hazard  (lu_hazard)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= RUN;
            md_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
            if (!pc_write && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Priority: reset > branch flush > mul/div occupancy > load-use stall.
    always_comb begin
        pc_write    = 1'b1;
        IF_ID_write = 1'b1;
        ID_bubble   = 1'b0;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        EX_hold     = 1'b0;
        md_done     = 1'b0;
        state_nxt   = state;
        md_cnt_nxt  = md_cnt;

        if (rst_i) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_bubble   = 1'b1;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            state_nxt   = RUN;
            md_cnt_nxt  = '0;
        end else if (branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            state_nxt   = RUN;
            md_cnt_nxt  = '0;
        end else if (state == MD_BUSY) begin
            if (md_cnt != '0) begin
                EX_hold     = 1'b1;
                pc_write    = 1'b0;
                IF_ID_write = 1'b0;
                md_cnt_nxt  = md_cnt - 4'd1;
            end else begin
                md_done   = 1'b1;
                state_nxt = RUN;
            end
        end else if (IE_md_start) begin
            if (MD_LATENCY == 1) begin
                md_done = 1'b1;
            end else begin
                // The start cycle is the first hold cycle, hence the -2 preload.
                EX_hold     = 1'b1;
                pc_write    = 1'b0;
                IF_ID_write = 1'b0;
                state_nxt   = MD_BUSY;
                md_cnt_nxt  = 4'(MD_LATENCY - 2);
            end
        end else if (lu_hazard) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_bubble   = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Two DUT instances (latency 4 / 4-bit counter, latency 1 / 16-bit counter) against a behavioural model.
module tb_hazard_stall_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ie_rt;
    logic       uses_rt, memread, md_start, br;
    logic [6:0] o [2];
    logic [3:0] cnt0;
    logic [15:0] cnt1;

    int  n_chk = 0, n_err = 0;
    bit  m_busy [2];
    int  m_rem  [2];
    int  m_cnt  [2];

    always #5 clk = ~clk;

    hazard_stall_controller #(.REG_AW(5), .MD_LATENCY(4), .CNT_W(4)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .ID_rs(id_rs), .ID_rt(id_rt), .ID_uses_rt(uses_rt),
        .IE_memread(memread), .IE_rt(ie_rt), .IE_md_start(md_start), .branch_taken(br),
        .pc_write(o[0][6]), .IF_ID_write(o[0][5]), .ID_bubble(o[0][4]), .IF_ID_flush(o[0][3]),
        .ID_EX_flush(o[0][2]), .EX_hold(o[0][1]), .md_done(o[0][0]), .stall_cnt(cnt0)
    );

    hazard_stall_controller #(.REG_AW(5), .MD_LATENCY(1), .CNT_W(16)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .ID_rs(id_rs), .ID_rt(id_rt), .ID_uses_rt(uses_rt),
        .IE_memread(memread), .IE_rt(ie_rt), .IE_md_start(md_start), .branch_taken(br),
        .pc_write(o[1][6]), .IF_ID_write(o[1][5]), .ID_bubble(o[1][4]), .IF_ID_flush(o[1][3]),
        .ID_EX_flush(o[1][2]), .EX_hold(o[1][1]), .md_done(o[1][0]), .stall_cnt(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int lat(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int cmax(input int i);
        return (i == 0) ? 15 : 65535;
    endfunction

    // Output vector: {pc_write, IF_ID_write, ID_bubble, IF_ID_flush, ID_EX_flush, EX_hold, md_done}.
    // m_rem counts the cycles still owed to a running mul/div, including its done cycle.
    function automatic void model(input int i, output logic [6:0] e, output bit nb, output int nr);
        bit hz;
        hz = memread && (ie_rt != 0) && (ie_rt == id_rs || (uses_rt && ie_rt == id_rt));
        e  = 7'b1100000;
        nb = m_busy[i];
        nr = m_rem[i];
        if (rst) begin
            e = 7'b0011100; nb = 0; nr = 0;
        end else if (br) begin
            e = 7'b1101100; nb = 0; nr = 0;
        end else if (m_busy[i]) begin
            if (m_rem[i] > 1) begin
                e = 7'b0000010; nr = m_rem[i] - 1;
            end else begin
                e = 7'b1100001; nb = 0; nr = 0;
            end
        end else if (md_start) begin
            if (lat(i) == 1) e = 7'b1100001;
            else begin
                e = 7'b0000010; nb = 1; nr = lat(i) - 1;
            end
        end else if (hz) begin
            e = 7'b0010000;
        end
    endfunction

    task automatic step(input string tag);
        logic [6:0] e [2];
        bit         nb [2];
        int         nr [2];
        #1;
        for (int i = 0; i < 2; i++) begin
            model(i, e[i], nb[i], nr[i]);
            chk($sformatf("%s/out%0d", tag, i), 32'(o[i]), 32'(e[i]));
            chk($sformatf("%s/cnt%0d", tag, i), (i == 0) ? 32'(cnt0) : 32'(cnt1), 32'(m_cnt[i]));
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) m_cnt[i] = 0;
            else if (!e[i][6] && m_cnt[i] < cmax(i)) m_cnt[i]++;
            m_busy[i] = nb[i];
            m_rem[i]  = nr[i];
        end
        @(negedge clk);
    endtask

    task automatic clr();
        rst = 0; id_rs = 0; id_rt = 0; ie_rt = 0;
        uses_rt = 0; memread = 0; md_start = 0; br = 0;
    endtask

    initial begin
        clr();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        step("reset");
        chk("reset_cnt", 32'(cnt0), 32'd0);
        rst = 0;
        step("idle");

        // load-use on rs, then the bubble clears it
        memread = 1; ie_rt = 2; id_rs = 2;
        step("lu_rs");
        clr();
        step("lu_after");

        // zero register and unused rt never stall
        memread = 1; ie_rt = 0; id_rs = 0;
        step("lu_zero");
        memread = 1; ie_rt = 3; id_rt = 3; id_rs = 1; uses_rt = 0;
        step("lu_rt_unused");
        uses_rt = 1;
        step("lu_rt_used");
        clr();

        // full mul/div occupancy
        md_start = 1;
        step("md_start");
        md_start = 0;
        repeat (4) step("md_run");

        // branch aborts mul/div in its second busy cycle
        md_start = 1;
        step("md_abort_start");
        md_start = 0;
        step("md_abort_b1");
        br = 1;
        step("md_abort_br");
        br = 0;
        repeat (3) step("md_abort_after");

        // branch beats a simultaneous load-use hazard
        memread = 1; ie_rt = 2; id_rs = 2; br = 1;
        step("br_vs_lu");
        clr();

        // counter saturation and reset
        memread = 1; ie_rt = 2; id_rs = 2;
        repeat (20) step("sat");
        chk("sat_hold", 32'(cnt0), 32'hF);
        rst = 1;
        step("sat_rst");
        chk("sat_rst_cnt", 32'(cnt0), 32'd0);
        clr();
        step("post_rst");

        repeat (400) begin
            rst      = ($urandom % 64) == 0;
            br       = ($urandom % 8) == 0;
            md_start = ($urandom % 5) == 0;
            memread  = $urandom % 2;
            uses_rt  = $urandom % 2;
            id_rs    = 5'($urandom % 4);
            id_rt    = 5'($urandom % 4);
            ie_rt    = 5'($urandom % 4);
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
